handshake_elastic_buffer: RTL

Two-slot elastic buffer on a handshake channel, placed between a data producer (constant, arithmetic, or control-merge unit) and its consumer. It registers data and valid on the output side and ready on the input side, breaking every combinational valid/ready path through it. It sustains one transfer per cycle with one cycle of latency and absorbs one cycle of downstream back-pressure without loss.

---
 rtl/handshake_pkg.sv | 12 +
 rtl/handshake_elastic_buffer.sv | 120 ++++++++++++
 2 files changed

// File: rtl/handshake_pkg.sv
// rtl/handshake_pkg.sv - shared types and constants for handshake channel blocks
package handshake_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } hs_eb_state_e;

    localparam int HS_EB_DEPTH = 2;

endpackage

// File: rtl/handshake_elastic_buffer.sv
// rtl/handshake_elastic_buffer.sv - two-slot elastic buffer, optional occupancy port via HANDSHAKE_EB_OCCUPANCY_EN
module handshake_elastic_buffer
    import handshake_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready
`ifdef HANDSHAKE_EB_OCCUPANCY_EN
    ,
    output logic [1:0]            occupancy
`endif
);

    hs_eb_state_e          state_q;
    hs_eb_state_e          state_d;
    logic [DATA_WIDTH-1:0] main_q;
    logic [DATA_WIDTH-1:0] skid_q;
    logic                  ins_ready_q;

    logic                  in_fire;
    logic                  out_fire;
    logic                  load_main_ins;
    logic                  load_main_skid;
    logic                  load_skid;

    // Outputs come straight from flops, so no input reaches them combinationally.
    assign ins_ready  = ins_ready_q;
    assign outs_valid = (state_q != EMPTY);
    assign outs       = main_q;

    assign in_fire  = ins_valid & ins_ready_q;
    assign out_fire = outs_valid & outs_ready;

    // Next-state and data-register load selection from the current fill level.
    always_comb begin
        state_d        = state_q;
        load_main_ins  = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    load_main_ins = 1'b1;
                    state_d       = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_main_ins = 1'b1;
                end else if (in_fire) begin
                    load_skid = 1'b1;
                    state_d   = FULL;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // ins_ready is low here, so only the drain side can move.
                if (out_fire) begin
                    load_main_skid = 1'b1;
                    state_d        = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // Fill-level state and the registered ready, which looks one step ahead.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= EMPTY;
            ins_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ins_ready_q <= (state_d != FULL);
        end
    end

    // Data registers: main drives outs, skid catches the word arriving during a stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_ins) begin
                main_q <= ins;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= ins;
            end
        end
    end

`ifdef HANDSHAKE_EB_OCCUPANCY_EN
    logic [1:0] occupancy_q;

    // Word count mirrors the state encoding (0, 1 or 2 words held).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occupancy_q <= 2'd0;
        end else begin
            occupancy_q <= state_d;
        end
    end

    assign occupancy = occupancy_q;
`endif

endmodule
